// File: rtl/filt_ppd_mac.sv
// filt_ppd_mac: polyphase FIR decimator multiply-add array.
// Accepts one sample per i_ena, emits one filtered sample per D accepts.
// Optional build macro FILT_PPD_ROUND_EN: round-half-up before the output shift.
module filt_ppd_mac #(
   parameter int unsigned gp_decimation_factor = 4,
   parameter int unsigned gp_coeff_length      = 8,
   parameter int unsigned gp_idata_width       = 8,
   parameter int unsigned gp_coeff_width       = 8,
   parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeff =
      {8'sd8, 8'sd7, 8'sd6, 8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1},
   parameter int unsigned gp_out_shift         = 0,
   parameter int unsigned gp_odata_width       = 19
) (
   input  logic                             i_clk,
   input  logic                             i_rst_an,
   input  logic                             i_ena,
   input  logic signed [gp_idata_width-1:0] i_data,
   output logic signed [gp_odata_width-1:0] o_data,
   output logic                             o_valid
);

   localparam int unsigned D  = gp_decimation_factor;
   localparam int unsigned N  = gp_coeff_length;
   localparam int unsigned IW = gp_idata_width;
   localparam int unsigned CW = gp_coeff_width;
   localparam int unsigned OW = gp_odata_width;
   localparam int unsigned NB = N / D;
   localparam int unsigned PW = $clog2(D);
   localparam int unsigned MW = IW + CW;
   localparam int unsigned SW = MW + $clog2(N);
   // one guard bit above the full sum absorbs the rounding offset
   localparam int unsigned EW = (SW + 1 > OW) ? SW + 1 : OW;

   localparam logic signed [EW-1:0] SAT_MAX = (EW'(1) << (OW - 1)) - EW'(1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

`ifdef FILT_PPD_ROUND_EN
   localparam int unsigned SH_M1 = (gp_out_shift > 0) ? gp_out_shift - 1 : 0;
   localparam logic signed [EW-1:0] RND_V =
      (gp_out_shift > 0) ? (EW'(1) << SH_M1) : '0;
`else
   localparam logic signed [EW-1:0] RND_V = '0;
`endif

   logic [PW-1:0]          r_phase;
   logic signed [IW-1:0]   r_tap  [N];
   logic signed [MW-1:0]   r_prod [N];
   logic                   r_s1;
   logic                   r_s2;

   logic signed [SW-1:0]   branch_sum [D];
   logic signed [SW-1:0]   full_sum;
   logic signed [EW-1:0]   ext_sum;
   logic signed [EW-1:0]   shifted;
   logic signed [EW-1:0]   sat_sum;

   // phase counter, delay line and trigger strobe (phase-0 accept)
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         r_phase <= '0;
         r_s1    <= 1'b0;
         for (int k = 0; k < N; k++) r_tap[k] <= '0;
      end else begin
         if (i_ena) begin
            r_phase  <= (r_phase == PW'(D - 1)) ? '0 : r_phase + PW'(1);
            r_tap[0] <= i_data;
            for (int k = 1; k < N; k++) r_tap[k] <= r_tap[k-1];
         end
         r_s1 <= i_ena && (r_phase == '0);
      end
   end

   // product stage: snapshot all taps times coefficients on the trigger
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         r_s2 <= 1'b0;
         for (int n = 0; n < N; n++) r_prod[n] <= '0;
      end else begin
         r_s2 <= r_s1;
         if (r_s1) begin
            for (int n = 0; n < N; n++)
               r_prod[n] <= MW'(r_tap[n]) * MW'($signed(gp_coeff[n*CW +: CW]));
         end
      end
   end

   // per-branch sums, full sum, optional rounding, shift and saturation
   always_comb begin
      full_sum = '0;
      for (int p = 0; p < D; p++) begin
         branch_sum[p] = '0;
         for (int k = 0; k < NB; k++)
            branch_sum[p] = branch_sum[p] + SW'(r_prod[p + k*D]);
         full_sum = full_sum + branch_sum[p];
      end
      ext_sum = EW'(full_sum) + RND_V;
      shifted = ext_sum >>> gp_out_shift;
      sat_sum = shifted;
      if (shifted > SAT_MAX)      sat_sum = SAT_MAX;
      else if (shifted < SAT_MIN) sat_sum = SAT_MIN;
   end

   // output register: update and pulse valid one cycle after the products
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= r_s2;
         if (r_s2) o_data <= OW'(sat_sum);
      end
   end

endmodule

// File: tb/tb_filt_ppd_mac.sv
// tb_filt_ppd_mac: directed bench for filt_ppd_mac, three parameterisations
// (default, 12-bit output, shift of 2) share one stimulus stream.
module tb_filt_ppd_mac;

   logic               clk;
   logic               rst_n;
   logic               ena;
   logic signed [7:0]  data;
   logic signed [18:0] d0;
   logic signed [11:0] d1;
   logic signed [18:0] d2;
   logic               v0, v1, v2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int q0[$], q1[$], q2[$], t0[$], acc[$];

`ifdef FILT_PPD_ROUND_EN
   localparam int R2 = 4;
`else
   localparam int R2 = 3;
`endif

   filt_ppd_mac dut0 (
      .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data),
      .o_data(d0), .o_valid(v0));

   filt_ppd_mac #(.gp_odata_width(12)) dut1 (
      .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data),
      .o_data(d1), .o_valid(v1));

   filt_ppd_mac #(.gp_out_shift(2)) dut2 (
      .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data),
      .o_data(d2), .o_valid(v2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // capture output pulses away from the active edge
   always @(negedge clk) begin
      if (v0) begin q0.push_back(int'(d0)); t0.push_back(cyc); end
      if (v1) q1.push_back(int'(d1));
      if (v2) q2.push_back(int'(d2));
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -999999;
   endfunction

   task automatic clear_q();
      q0.delete(); q1.delete(); q2.delete(); t0.delete(); acc.delete();
   endtask

   task automatic drive(input logic en, input int x);
      @(negedge clk);
      ena  = en;
      data = 8'(x);
      if (en) acc.push_back(cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ena = 1'b0; data = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      clear_q();
   endtask

   initial begin
      int n_acc;
      int i;
      logic en;
      rst_n = 1'b0; ena = 1'b0; data = '0;
      repeat (3) @(negedge clk);
      check("rst_v0", int'(v0), 0);
      check("rst_d0", int'(d0), 0);
      check("rst_v1", int'(v1), 0);
      rst_n = 1'b1;
      clear_q();

      // impulse
      drive(1'b1, 1);
      repeat (15) drive(1'b1, 0);
      idle(6);
      check("imp_cnt", q0.size(), 4);
      check("imp_y0", at(q0, 0), 1);
      check("imp_y1", at(q0, 1), 5);
      check("imp_y2", at(q0, 2), 0);
      check("imp_y3", at(q0, 3), 0);
      check("imp_lat", at(t0, 0), acc[0] + 2);
      for (int k = 1; k < 4; k++)
         check($sformatf("imp_gap%0d", k), at(t0, k) - at(t0, k-1), 4);

      // step
      do_reset();
      repeat (12) drive(1'b1, 1);
      idle(6);
      check("stp_cnt", q0.size(), 3);
      check("stp_y0", at(q0, 0), 1);
      check("stp_y1", at(q0, 1), 15);
      check("stp_y2", at(q0, 2), 36);
      check("stp12_y2", at(q1, 2), 36);
      check("rnd_y0", at(q2, 0), 0);
      check("rnd_y1", at(q2, 1), R2);
      check("rnd_y2", at(q2, 2), 9);

      // negative full scale
      do_reset();
      repeat (16) drive(1'b1, -128);
      idle(6);
      check("neg_y1", at(q0, 1), -1920);
      check("neg_y3", at(q0, 3), -4608);
      check("neg12_y1", at(q1, 1), -1920);
      check("neg12_y3", at(q1, 3), -2048);
      check("negsh_y3", at(q2, 3), -1152);

      // positive full scale
      do_reset();
      repeat (16) drive(1'b1, 127);
      idle(6);
      check("pos_y3", at(q0, 3), 4572);
      check("pos12_y3", at(q1, 3), 2047);

      // stall: enable pattern 1-0-0-1 repeating
      do_reset();
      n_acc = 0;
      i = 0;
      while (n_acc < 12) begin
         en = ((i % 4) == 0) || ((i % 4) == 3);
         drive(en, en ? 1 : 7);
         if (en) n_acc++;
         i++;
      end
      idle(6);
      check("stl_cnt", q0.size(), 3);
      check("stl_y0", at(q0, 0), 1);
      check("stl_y1", at(q0, 1), 15);
      check("stl_y2", at(q0, 2), 36);
      for (int k = 0; k < 3; k++)
         check($sformatf("stl_t%0d", k), at(t0, k), at(acc, 4*k) + 2);

      // reset while the second trigger is in flight
      do_reset();
      repeat (5) drive(1'b1, 1);
      @(negedge clk);
      rst_n = 1'b0; ena = 1'b0;
      #1;
      check("mid_v0", int'(v0), 0);
      check("mid_d0", int'(d0), 0);
      check("mid_pre", q0.size(), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(6);
      check("mid_stale", q0.size(), 1);
      clear_q();
      repeat (12) drive(1'b1, 1);
      idle(6);
      check("mid_cnt", q0.size(), 3);
      check("mid_y0", at(q0, 0), 1);
      check("mid_y1", at(q0, 1), 15);
      check("mid_y2", at(q0, 2), 36);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
